// File: rtl/ram_sync_nolatch_mrmw_pkg.sv
// Shared constants and state encoding for the multi-read/multi-write register-file RAM.
// Default widths and the clear/ready state encoding live here.
package ram_sync_nolatch_mrmw_pkg;

    localparam int ADDR_LEN = 5;
    localparam int DATA_LEN = 16;

    typedef enum logic {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_mrmw_clr_fsm.sv
// Clear-sweep controller: walks a pointer over every entry after reset or on request,
// and gates user writes while the sweep runs or a clear is being accepted.
module ram_mrmw_clr_fsm
    import ram_sync_nolatch_mrmw_pkg::*;
#(
    parameter int AW    = ADDR_LEN,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          clr_req,
    output logic          busy,
    output logic          wr_gate,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    ram_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= RAM_ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RAM_ST_CLEAR: begin
                if (ptr_q == LAST) begin
                    ptr_d   = '0;
                    state_d = RAM_ST_READY;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RAM_ST_READY: begin
                if (clr_req) begin
                    state_d = RAM_ST_CLEAR;
                end
            end
            default: state_d = RAM_ST_CLEAR;
        endcase
    end

    // A clear request drops the writes presented in the same cycle.
    assign busy     = (state_q == RAM_ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr_q;
    assign wr_gate  = (state_q == RAM_ST_READY) && !clr_req;

endmodule

// File: rtl/ram_sync_nolatch_mrmw.sv
// Parametrised register-file RAM: NUM_RD combinational read ports, NUM_WR synchronous
// write ports (highest index wins), optional bypass and hard-wired zero entry.
module ram_sync_nolatch_mrmw
    import ram_sync_nolatch_mrmw_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = ADDR_LEN,
    parameter int BRAM_DATA_WIDTH = DATA_LEN,
    parameter int DATA_DEPTH      = 32,
    parameter int NUM_RD          = 6,
    parameter int NUM_WR          = 2,
    parameter int BYPASS          = 0,
    parameter int ZERO_REG        = 0
) (
    input  logic                                clk,
    input  logic                                reset_x,
    input  logic [NUM_RD*BRAM_ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_RD*BRAM_DATA_WIDTH-1:0]   rdata,
    input  logic [NUM_WR*BRAM_ADDR_WIDTH-1:0]   waddr,
    input  logic [NUM_WR*BRAM_DATA_WIDTH-1:0]   wdata,
    input  logic [NUM_WR-1:0]                   we,
    input  logic                                clr_req,
    output logic                                busy
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    logic [DW-1:0] mem [DATA_DEPTH];

    logic          wr_gate;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic [NUM_WR-1:0] wr_en;
    logic [AW-1:0] waddr_a [NUM_WR];
    logic [DW-1:0] wdata_a [NUM_WR];

    ram_mrmw_clr_fsm #(
        .AW    (AW),
        .DEPTH (DATA_DEPTH)
    ) u_clr_fsm (
        .clk      (clk),
        .reset_x  (reset_x),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_gate  (wr_gate),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Effective enables: only writes that will actually land, so bypass sees the same set.
    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign waddr_a[gi] = waddr[gi*AW +: AW];
            assign wdata_a[gi] = wdata[gi*DW +: DW];
            assign wr_en[gi]   = we[gi] && wr_gate
                                 && (int'(waddr_a[gi]) < DATA_DEPTH)
                                 && !((ZERO_REG != 0) && (waddr_a[gi] == '0));
        end
    endgenerate

    // Ascending port order: the last matching assignment, i.e. the highest port, wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr[IW-1:0]] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) begin
                    mem[waddr_a[j][IW-1:0]] <= wdata_a[j];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;

            assign ra = raddr[gi*AW +: AW];

            always_comb begin
                rd = '0;
                if (!busy && (int'(ra) < DATA_DEPTH)) begin
                    rd = mem[ra[IW-1:0]];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NUM_WR; j++) begin
                            if (wr_en[j] && (waddr_a[j] == ra)) begin
                                rd = wdata_a[j];
                            end
                        end
                    end
                end
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd = '0;
                end
            end

            assign rdata[gi*DW +: DW] = rd;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_nolatch_mrmw.sv
// Random and directed stimulus against two instances (plain, and bypass+zero-entry),
// checked every cycle against an array model with a sweep countdown.
module tb_ram_sync_nolatch_mrmw;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int NR    = 6;
    localparam int NW    = 2;

    logic              clk = 1'b0;
    logic              reset_x;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata0, rdata1;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NW-1:0]     we;
    logic              clr_req;
    logic              busy0, busy1;

    int total = 0;
    int bad   = 0;
    int nstep = 0;

    logic [DW-1:0] m [DEPTH];
    int            clr_left;

    always #5 clk = ~clk;

    ram_sync_nolatch_mrmw #(
        .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(DEPTH),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(0)
    ) u_plain (
        .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata0),
        .waddr(waddr), .wdata(wdata), .we(we), .clr_req(clr_req), .busy(busy0)
    );

    ram_sync_nolatch_mrmw #(
        .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(DEPTH),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)
    ) u_byp (
        .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata1),
        .waddr(waddr), .wdata(wdata), .we(we), .clr_req(clr_req), .busy(busy1)
    );

    task automatic chk(input string tag, input int idx, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] step=%0d observed=%h expected=%h", tag, idx, nstep, obs, exp);
        end
    endtask

    function automatic int ra(input int i);
        return int'(raddr[i*AW +: AW]);
    endfunction

    function automatic int wa(input int j);
        return int'(waddr[j*AW +: AW]);
    endfunction

    function automatic logic model_busy();
        return (!reset_x) || (clr_left > 0);
    endfunction

    // Read result from the rules: zero while sweeping, zero out of range, zero entry, bypass.
    function automatic logic [DW-1:0] exp_rd(input int a, input bit byp, input bit zr);
        logic [DW-1:0] r;
        if (model_busy()) return '0;
        if (zr && a == 0) return '0;
        if (a >= DEPTH) return '0;
        r = m[a];
        if (byp && !clr_req) begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa(j) == a) r = wdata[j*DW +: DW];
            end
        end
        return r;
    endfunction

    task automatic model_edge();
        if (!reset_x) begin
            clr_left = DEPTH;
        end else if (clr_left > 0) begin
            m[DEPTH - clr_left] = '0;
            clr_left--;
        end else if (clr_req) begin
            clr_left = DEPTH;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa(j) < DEPTH) m[wa(j)] = wdata[j*DW +: DW];
            end
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] eb;
        eb = {{(DW-1){1'b0}}, model_busy()};
        chk("busy_plain", 0, {{(DW-1){1'b0}}, busy0}, eb);
        chk("busy_byp", 0, {{(DW-1){1'b0}}, busy1}, eb);
        for (int i = 0; i < NR; i++) begin
            chk("rd_plain", i, rdata0[i*DW +: DW], exp_rd(ra(i), 1'b0, 1'b0));
            chk("rd_byp", i, rdata1[i*DW +: DW], exp_rd(ra(i), 1'b1, 1'b1));
        end
    endtask

    // Inputs are set just after a rising edge; check mid-cycle, then advance one edge.
    task automatic step();
        #4;
        check_all();
        $display("step %0d rst_n=%0b busy=%0b/%0b we=%b clr=%0b waddr0=%0d waddr1=%0d",
                 nstep, reset_x, busy0, busy1, we, clr_req, wa(0), wa(1));
        @(posedge clk);
        model_edge();
        nstep++;
        #1;
    endtask

    task automatic set_r(input int i, input int a);
        raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_w(input int j, input bit en, input int a, input logic [DW-1:0] d);
        we[j] = en;
        waddr[j*AW +: AW] = AW'(a);
        wdata[j*DW +: DW] = d;
    endtask

    task automatic rand_in(input bit allow_we, input int clr_pct);
        for (int j = 0; j < NW; j++) begin
            set_w(j, allow_we && ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, DEPTH + 8)), DW'($urandom));
        end
        for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 1) == 1) set_r(i, wa(int'($urandom_range(0, NW - 1))));
            else set_r(i, int'($urandom_range(0, (1 << AW) - 1)));
        end
        clr_req = (int'($urandom_range(0, 99)) < clr_pct);
    endtask

    task automatic idle_in();
        we = '0;
        clr_req = 1'b0;
    endtask

    initial begin
        we = '0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;
        reset_x = 1'b0;
        clr_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) m[a] = '0;

        repeat (3) @(posedge clk);
        #1;
        rand_in(1'b1, 20);
        step();

        // Sweep after reset release; writes and clears during it are ignored.
        reset_x = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            rand_in(1'b1, 10);
            step();
        end

        // Every address reads zero, plus some out-of-range addresses.
        for (int base = 0; base < DEPTH + NR; base += NR) begin
            idle_in();
            for (int i = 0; i < NR; i++) set_r(i, base + i);
            step();
        end

        // Same-address write conflict: port 1 wins.
        set_w(0, 1'b1, 5, 16'hAAAA);
        set_w(1, 1'b1, 5, 16'h5555);
        for (int i = 0; i < NR; i++) set_r(i, 5);
        step();
        idle_in();
        step();

        // Bypass on read port 3.
        set_w(0, 1'b1, 7, 16'h1234);
        set_w(1, 1'b0, 0, 16'h0000);
        set_r(3, 7);
        step();
        idle_in();
        step();

        // Entry 0 write.
        set_w(0, 1'b1, 0, 16'hFFFF);
        set_r(0, 0);
        set_r(1, 0);
        step();
        idle_in();
        step();

        // Clear request drops the same-cycle write.
        set_w(0, 1'b1, 3, 16'h0077);
        step();
        clr_req = 1'b1;
        set_w(0, 1'b1, 3, 16'h0009);
        for (int i = 0; i < NR; i++) set_r(i, 3);
        step();
        for (int k = 0; k < DEPTH; k++) begin
            rand_in(1'b1, 10);
            step();
        end
        idle_in();
        for (int i = 0; i < NR; i++) set_r(i, 3);
        step();

        // Random traffic in READY with occasional clears.
        for (int k = 0; k < 150; k++) begin
            rand_in(1'b1, 2);
            step();
        end

        // Reset pulsed in the middle of a sweep.
        idle_in();
        clr_req = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            rand_in(1'b1, 0);
            step();
        end
        reset_x = 1'b0;
        rand_in(1'b1, 0);
        step();
        step();
        reset_x = 1'b1;
        for (int k = 0; k < DEPTH + 20; k++) begin
            rand_in(1'b1, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
